// File: rtl/dump_pkg.sv
// Shared definitions for the debug-dump sequencer: FSM encodings,
// dump port widths and the fixed header/substitute byte values.
// Optional build macro: DUMP_CHECKSUM_EN adds the CSUM state.
package dump_pkg;

  localparam int CS_W  = 3;
  localparam int POS_W = 5;

  localparam logic [7:0] HDR_BASE_DEF = 8'hA0;
  localparam logic [7:0] SUB_BYTE     = 8'hEE;

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_ADDR, S_WAITV, S_SEND, S_TXGAP, S_NEXT, S_CSUM
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_ADDR, S_WAITV, S_SEND, S_TXGAP, S_NEXT
  } state_t;
`endif

endpackage

// File: rtl/tx_pacer.sv
// One-byte hand-off to the UART transmitter. A request fires when the
// transmitter is idle. The strobe is registered, so o_tx_data is stable
// for the whole strobe cycle, and a guard keeps strobes at least three
// cycles apart even when the requester re-requests immediately.
module tx_pacer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] tx_byte,
  input  logic       i_tx_busy,
  output logic       o_tx_wr,
  output logic [7:0] o_tx_data,
  output logic       done
);

  logic gap_q;

  assign done = req & ~i_tx_busy & ~o_tx_wr & ~gap_q;

  // Register the strobe, the byte it carries, and the guard cycle after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_tx_wr   <= 1'b0;
      o_tx_data <= 8'h00;
      gap_q     <= 1'b0;
    end else begin
      o_tx_wr <= done;
      gap_q   <= o_tx_wr;
      if (done) o_tx_data <= tx_byte;
    end
  end

endmodule

// File: rtl/dump_ctl.sv
// Debug-dump sequencer. It walks every unit and FIFO entry of the CPU
// dump port. For each unit it sends a header byte, then one byte per
// entry. A read that times out is replaced by a substitute byte and
// flags o_err.
// Optional build macro: DUMP_CHECKSUM_EN appends an XOR checksum byte.
//
// state | meaning
// IDLE  | waiting for i_start; dump port holds its last select/pos
// HDR   | load header byte HDR_BASE | chip
// ADDR  | present chip/pos on the dump port, clear the read timer
// WAITV | wait for i_dmp_valid or the read timeout
// SEND  | hand the byte to tx_pacer once the transmitter is idle
// TXGAP | one settle cycle so the transmitter's busy can rise
// NEXT  | advance pos, then chip, or finish
// CSUM  | load the checksum byte (DUMP_CHECKSUM_EN only)
module dump_ctl
  import dump_pkg::*;
#(
  parameter int         NCHIPS   = 5,
  parameter int         DEPTH    = 32,
  parameter int         TIMEOUT  = 16,
  parameter logic [7:0] HDR_BASE = HDR_BASE_DEF
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic [CS_W-1:0]  o_dmp_chip_select,
  output logic [POS_W-1:0] o_dmp_fifo_pos,
  input  logic [7:0]       i_dmp_data,
  input  logic             i_dmp_valid,
  input  logic             i_tx_busy,
  output logic             o_tx_wr,
  output logic [7:0]       o_tx_data,
  output logic             o_active,
  output logic             o_err
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CS_W-1:0]  CHIP_LAST = CS_W'(NCHIPS - 1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(DEPTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  state_t             state, state_nx;
  logic [CS_W-1:0]    chip;
  logic [POS_W-1:0]   pos;
  logic [TMO_W-1:0]   tmo;
  logic [7:0]         byte_q;
  logic               hdr_flag;
  logic               pace_done;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]         csum;
  logic               csum_flag;
`endif

  assign o_active = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode; i_start only matters in IDLE, so it is ignored mid-dump.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_start) state_nx = S_HDR;
      S_HDR:   state_nx = S_SEND;
      S_ADDR:  state_nx = S_WAITV;
      S_WAITV: if (i_dmp_valid || tmo == TMO_LAST) state_nx = S_SEND;
      S_SEND:  if (pace_done) state_nx = S_TXGAP;
      S_TXGAP: begin
        if (hdr_flag) state_nx = S_ADDR;
`ifdef DUMP_CHECKSUM_EN
        else if (csum_flag) state_nx = S_IDLE;
`endif
        else state_nx = S_NEXT;
      end
      S_NEXT: begin
        if (pos != POS_LAST)        state_nx = S_ADDR;
        else if (chip != CHIP_LAST) state_nx = S_HDR;
`ifdef DUMP_CHECKSUM_EN
        else                        state_nx = S_CSUM;
`else
        else                        state_nx = S_IDLE;
`endif
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM:  state_nx = S_SEND;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // Counters, byte register, dump-port address and sticky error flag.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      chip              <= '0;
      pos               <= '0;
      tmo               <= '0;
      byte_q            <= 8'h00;
      hdr_flag          <= 1'b0;
      o_err             <= 1'b0;
      o_dmp_chip_select <= '0;
      o_dmp_fifo_pos    <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum              <= 8'h00;
      csum_flag         <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          chip  <= '0;
          pos   <= '0;
          o_err <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
          csum      <= 8'h00;
          csum_flag <= 1'b0;
`endif
        end
        S_HDR: begin
          byte_q   <= HDR_BASE | {{(8 - CS_W){1'b0}}, chip};
          hdr_flag <= 1'b1;
        end
        S_ADDR: begin
          o_dmp_chip_select <= chip;
          o_dmp_fifo_pos    <= pos;
          tmo               <= '0;
        end
        S_WAITV: begin
          if (i_dmp_valid) begin
            byte_q <= i_dmp_data;
          end else if (tmo == TMO_LAST) begin
            byte_q <= SUB_BYTE;
            o_err  <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_SEND: if (pace_done) csum <= csum ^ byte_q;
        S_CSUM: begin
          byte_q    <= csum;
          csum_flag <= 1'b1;
        end
`endif
        S_TXGAP: hdr_flag <= 1'b0;
        S_NEXT: begin
          if (pos != POS_LAST) begin
            pos <= pos + 1'b1;
          end else if (chip != CHIP_LAST) begin
            chip <= chip + 1'b1;
            pos  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  tx_pacer u_pacer (
    .clk       (clk),
    .rst       (i_rst),
    .req       (state == S_SEND),
    .tx_byte   (byte_q),
    .i_tx_busy (i_tx_busy),
    .o_tx_wr   (o_tx_wr),
    .o_tx_data (o_tx_data),
    .done      (pace_done)
  );

endmodule
